// File: rtl/frame_pkg.sv
// Shared types and default sizing for the frame bank packager.
package frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DROP   = 2'd2
    } state_t;

    localparam int PIXEL_W_DEF      = 8;
    localparam int IN_ADDR_W_DEF    = 24;
    localparam int OFFSET_W_DEF     = 17;
    localparam int FRAME_PIXELS_DEF = 76800;
    localparam int NUM_BANKS_DEF    = 2;

endpackage

// File: rtl/frame_bank_ctrl.sv
// Bank rotation: tracks the bank being written, the last completed bank,
// and the pixel count / done pulse of the frame that just closed.
module frame_bank_ctrl
    import frame_pkg::*;
#(
    parameter int OFFSET_W  = OFFSET_W_DEF,
    parameter int NUM_BANKS = NUM_BANKS_DEF,
    localparam int BANK_W   = $clog2(NUM_BANKS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                frame_end_i,
    input  logic [OFFSET_W:0]   pix_count_i,
    output logic [BANK_W-1:0]   wr_bank_o,
    output logic [BANK_W-1:0]   done_bank_o,
    output logic [OFFSET_W:0]   frame_count_o,
    output logic                frame_done_o
);

    logic [BANK_W-1:0] wr_bank_q, wr_bank_d;
    logic [BANK_W-1:0] done_bank_q, done_bank_d;
    logic [OFFSET_W:0] frame_count_q, frame_count_d;
    logic              frame_done_q, frame_done_d;

    always_comb begin
        wr_bank_d     = wr_bank_q;
        done_bank_d   = done_bank_q;
        frame_count_d = frame_count_q;
        frame_done_d  = frame_end_i;
        if (frame_end_i) begin
            done_bank_d   = wr_bank_q;
            frame_count_d = pix_count_i;
            // NUM_BANKS is a power of two, so natural overflow is the modulo
            wr_bank_d     = wr_bank_q + BANK_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_q     <= '0;
            done_bank_q   <= BANK_W'(NUM_BANKS - 1);
            frame_count_q <= '0;
            frame_done_q  <= 1'b0;
        end else begin
            wr_bank_q     <= wr_bank_d;
            done_bank_q   <= done_bank_d;
            frame_count_q <= frame_count_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign wr_bank_o     = wr_bank_q;
    assign done_bank_o   = done_bank_q;
    assign frame_count_o = frame_count_q;
    assign frame_done_o  = frame_done_q;

endmodule

// File: rtl/frame_bank_packager.sv
// Packs an address/pixel stream into BRAM writes across rotating frame banks;
// owns the IDLE/STREAM/DROP FSM and the one-cycle write path.
module frame_bank_packager
    import frame_pkg::*;
#(
    parameter int PIXEL_W      = PIXEL_W_DEF,
    parameter int IN_ADDR_W    = IN_ADDR_W_DEF,
    parameter int OFFSET_W     = OFFSET_W_DEF,
    parameter int FRAME_PIXELS = FRAME_PIXELS_DEF,
    parameter int NUM_BANKS    = NUM_BANKS_DEF,
    localparam int BANK_W      = $clog2(NUM_BANKS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       addr_axiiv,
    input  logic [IN_ADDR_W-1:0]       addr_axiid,
    input  logic                       pixel_axiiv,
    input  logic [PIXEL_W-1:0]         pixel_axiid,
    input  logic                       frame_end_axiiv,
    output logic                       axiov,
    output logic [BANK_W+OFFSET_W-1:0] addr_axiod,
    output logic [PIXEL_W-1:0]         pixel_axiod,
    output logic [BANK_W-1:0]          done_bank,
    output logic                       frame_done,
    output logic [OFFSET_W:0]          frame_count,
    output logic                       err
);

    localparam logic [IN_ADDR_W-1:0] ADDR_LIM = IN_ADDR_W'(FRAME_PIXELS);
    localparam logic [OFFSET_W-1:0]  LAST_OFF = OFFSET_W'(FRAME_PIXELS - 1);

    state_t                     state_q, state_d, st_eff;
    logic [OFFSET_W-1:0]        offset_q, offset_d, off_eff;
    logic [OFFSET_W:0]          cnt_q, cnt_d, close_cnt;
    logic                       err_q, err_d;
    logic                       axiov_q, axiov_d;
    logic [BANK_W+OFFSET_W-1:0] addr_q, addr_d;
    logic [PIXEL_W-1:0]         pix_q, pix_d;
    logic                       pix_acc;
    logic [BANK_W-1:0]          wr_bank;

    always_comb begin
        st_eff   = state_q;
        off_eff  = offset_q;
        err_d    = err_q;
        axiov_d  = 1'b0;
        addr_d   = addr_q;
        pix_d    = pix_q;
        cnt_d    = cnt_q;
        pix_acc  = 1'b0;

        // An address word takes effect before any pixel in the same cycle
        if (addr_axiiv) begin
            if (addr_axiid < ADDR_LIM) begin
                st_eff  = ST_STREAM;
                off_eff = addr_axiid[OFFSET_W-1:0];
            end else begin
                st_eff  = ST_DROP;
                err_d   = 1'b1;
            end
        end

        state_d  = st_eff;
        offset_d = off_eff;
        pix_acc  = pixel_axiiv && (st_eff == ST_STREAM);

        if (pix_acc) begin
            axiov_d = 1'b1;
            addr_d  = {wr_bank, off_eff};
            pix_d   = pixel_axiid;
            cnt_d   = cnt_q + (OFFSET_W+1)'(1);
            if (off_eff == LAST_OFF) state_d  = ST_DROP;
            else                     offset_d = off_eff + OFFSET_W'(1);
        end else if (pixel_axiiv && st_eff == ST_DROP) begin
            err_d = 1'b1;
        end

        close_cnt = cnt_q + (OFFSET_W+1)'(pix_acc);

        // Closing frame: a same-cycle address seeds the next bank instead of IDLE
        if (frame_end_axiiv) begin
            cnt_d = '0;
            if (!addr_axiiv) state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            offset_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            axiov_q  <= 1'b0;
            addr_q   <= '0;
            pix_q    <= '0;
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            axiov_q  <= axiov_d;
            addr_q   <= addr_d;
            pix_q    <= pix_d;
        end
    end

    frame_bank_ctrl #(
        .OFFSET_W  (OFFSET_W),
        .NUM_BANKS (NUM_BANKS)
    ) u_bank_ctrl (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_end_i   (frame_end_axiiv),
        .pix_count_i   (close_cnt),
        .wr_bank_o     (wr_bank),
        .done_bank_o   (done_bank),
        .frame_count_o (frame_count),
        .frame_done_o  (frame_done)
    );

    assign axiov       = axiov_q;
    assign addr_axiod  = addr_q;
    assign pixel_axiod = pix_q;
    assign err         = err_q;

endmodule

// File: tb/tb_frame_bank_packager.sv
// Directed vector bench for frame_bank_packager with default parameters.
module tb_frame_bank_packager;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        addr_axiiv = 1'b0;
    logic [23:0] addr_axiid = '0;
    logic        pixel_axiiv = 1'b0;
    logic [7:0]  pixel_axiid = '0;
    logic        frame_end_axiiv = 1'b0;
    logic        axiov;
    logic [17:0] addr_axiod;
    logic [7:0]  pixel_axiod;
    logic [0:0]  done_bank;
    logic        frame_done;
    logic [17:0] frame_count;
    logic        err;

    int errors = 0;
    int checks = 0;

    frame_bank_packager dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .addr_axiiv      (addr_axiiv),
        .addr_axiid      (addr_axiid),
        .pixel_axiiv     (pixel_axiiv),
        .pixel_axiid     (pixel_axiid),
        .frame_end_axiiv (frame_end_axiiv),
        .axiov           (axiov),
        .addr_axiod      (addr_axiod),
        .pixel_axiod     (pixel_axiod),
        .done_bank       (done_bank),
        .frame_done      (frame_done),
        .frame_count     (frame_count),
        .err             (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [23:0] ad;
        logic        pv;
        logic [7:0]  px;
        logic        fe;
        logic        eax;
        logic [17:0] ea;
        logic [7:0]  ep;
        logic        ee;
        logic        efd;
        logic        edb;
        logic [17:0] efc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic av, logic [23:0] ad, logic pv, logic [7:0] px,
                                logic fe, logic eax, logic [17:0] ea, logic [7:0] ep,
                                logic ee, logic efd, logic edb, logic [17:0] efc);
        vec_t v;
        v.av = av; v.ad = ad; v.pv = pv; v.px = px; v.fe = fe;
        v.eax = eax; v.ea = ea; v.ep = ep; v.ee = ee; v.efd = efd;
        v.edb = edb; v.efc = efc;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(logic av, logic [23:0] ad, logic pv, logic [7:0] px, logic fe);
        addr_axiiv = av; addr_axiid = ad; pixel_axiiv = pv; pixel_axiid = px;
        frame_end_axiiv = fe;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // av  addr      pv px     fe | axiov addr     data   err fd db fc
        vecs.push_back(mk(0, 24'h0,     1, 8'h11, 0, 0, 18'h0,     8'h00, 0, 0, 1, 0));
        vecs.push_back(mk(1, 24'h10,    0, 8'h00, 0, 0, 18'h0,     8'h00, 0, 0, 1, 0));
        vecs.push_back(mk(0, 24'h0,     1, 8'hA1, 0, 1, 18'h10,    8'hA1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 24'h0,     1, 8'hB2, 0, 1, 18'h11,    8'hB2, 0, 0, 1, 0));
        vecs.push_back(mk(0, 24'h0,     1, 8'hC3, 0, 1, 18'h12,    8'hC3, 0, 0, 1, 0));
        vecs.push_back(mk(0, 24'h0,     0, 8'h00, 0, 0, 18'h0,     8'h00, 0, 0, 1, 0));
        vecs.push_back(mk(1, 24'd100,   1, 8'h55, 0, 1, 18'd100,   8'h55, 0, 0, 1, 0));
        vecs.push_back(mk(0, 24'h0,     1, 8'h56, 0, 1, 18'd101,   8'h56, 0, 0, 1, 0));
        vecs.push_back(mk(0, 24'h0,     1, 8'h57, 1, 1, 18'd102,   8'h57, 0, 1, 0, 6));
        vecs.push_back(mk(0, 24'h0,     0, 8'h00, 0, 0, 18'h0,     8'h00, 0, 0, 0, 6));
        vecs.push_back(mk(0, 24'h0,     1, 8'h99, 0, 0, 18'h0,     8'h00, 0, 0, 0, 6));
        vecs.push_back(mk(1, 24'd76799, 0, 8'h00, 0, 0, 18'h0,     8'h00, 0, 0, 0, 6));
        vecs.push_back(mk(0, 24'h0,     1, 8'h7E, 0, 1, 18'h32BFF, 8'h7E, 0, 0, 0, 6));
        vecs.push_back(mk(0, 24'h0,     1, 8'h7F, 0, 0, 18'h0,     8'h00, 1, 0, 0, 6));
        vecs.push_back(mk(0, 24'h0,     0, 8'h00, 0, 0, 18'h0,     8'h00, 1, 0, 0, 6));
        vecs.push_back(mk(1, 24'd5,     0, 8'h00, 0, 0, 18'h0,     8'h00, 1, 0, 0, 6));
        vecs.push_back(mk(0, 24'h0,     1, 8'h20, 0, 1, 18'h20005, 8'h20, 1, 0, 0, 6));
        vecs.push_back(mk(0, 24'h0,     0, 8'h00, 1, 0, 18'h0,     8'h00, 1, 1, 1, 2));
        vecs.push_back(mk(0, 24'h0,     0, 8'h00, 1, 0, 18'h0,     8'h00, 1, 1, 0, 0));
        vecs.push_back(mk(1, 24'd7,     1, 8'h33, 1, 1, 18'h20007, 8'h33, 1, 1, 1, 1));
        vecs.push_back(mk(0, 24'h0,     1, 8'h34, 0, 1, 18'h00008, 8'h34, 1, 0, 1, 1));

        drive(0, 0, 0, 0, 0);
        #12;
        chk("reset axiov", 32'(axiov), 32'd0);
        chk("reset addr", 32'(addr_axiod), 32'd0);
        chk("reset data", 32'(pixel_axiod), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        chk("reset frame_done", 32'(frame_done), 32'd0);
        chk("reset frame_count", 32'(frame_count), 32'd0);
        chk("reset done_bank", 32'(done_bank), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].av, vecs[i].ad, vecs[i].pv, vecs[i].px, vecs[i].fe);
            step();
            chk($sformatf("v%0d axiov", i), 32'(axiov), 32'(vecs[i].eax));
            if (vecs[i].eax) begin
                chk($sformatf("v%0d addr", i), 32'(addr_axiod), 32'(vecs[i].ea));
                chk($sformatf("v%0d data", i), 32'(pixel_axiod), 32'(vecs[i].ep));
            end
            chk($sformatf("v%0d err", i), 32'(err), 32'(vecs[i].ee));
            chk($sformatf("v%0d frame_done", i), 32'(frame_done), 32'(vecs[i].efd));
            chk($sformatf("v%0d done_bank", i), 32'(done_bank), 32'(vecs[i].edb));
            chk($sformatf("v%0d frame_count", i), 32'(frame_count), 32'(vecs[i].efc));
        end

        // Mid-stream asynchronous reset: outputs clear without a clock edge
        drive(0, 0, 1, 8'hEE, 0);
        step();
        chk("pre-reset axiov", 32'(axiov), 32'd1);
        chk("pre-reset addr", 32'(addr_axiod), 32'd9);
        #2 rst_n = 1'b0;
        #1;
        chk("async axiov", 32'(axiov), 32'd0);
        chk("async addr", 32'(addr_axiod), 32'd0);
        chk("async data", 32'(pixel_axiod), 32'd0);
        chk("async err", 32'(err), 32'd0);
        chk("async frame_count", 32'(frame_count), 32'd0);
        chk("async done_bank", 32'(done_bank), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk($sformatf("post-reset pix%0d axiov", i), 32'(axiov), 32'd0);
            chk($sformatf("post-reset pix%0d frame_done", i), 32'(frame_done), 32'd0);
        end

        // Out-of-range start address, then recovery through a valid address
        drive(1, 24'h01FFFF, 0, 0, 0);
        step();
        chk("bad addr err", 32'(err), 32'd1);
        chk("bad addr axiov", 32'(axiov), 32'd0);
        drive(0, 0, 1, 8'h41, 0);
        step();
        chk("drop pixel axiov", 32'(axiov), 32'd0);
        drive(1, 24'd3, 1, 8'h42, 0);
        step();
        chk("recover axiov", 32'(axiov), 32'd1);
        chk("recover addr", 32'(addr_axiod), 32'd3);
        chk("recover data", 32'(pixel_axiod), 32'h42);
        drive(0, 0, 0, 0, 0);
        step();
        chk("hold axiov", 32'(axiov), 32'd0);
        chk("hold addr", 32'(addr_axiod), 32'd3);
        chk("hold data", 32'(pixel_axiod), 32'h42);
        chk("sticky err", 32'(err), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
